// File: rtl/shift_right_pipe.sv
// shift_right_pipe: two-stage group barrel shifter (right shift) with valid/ready flow control.
// Define SHIFT_RIGHT_PIPE_ROTATE_EN to enable rotate mode; otherwise every beat is a fill shift.
module shift_right_pipe #(
   parameter int GRP_W     = 5,
   parameter int GROUPS    = 10,
   parameter int SHIFT_W   = 3,
   parameter int MAX_SHIFT = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [GROUPS*GRP_W-1:0]   in,
   input  logic [SHIFT_W-1:0]        shift,
   input  logic [GRP_W-1:0]          fill,
   input  logic                      mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [GROUPS*GRP_W-1:0]   out,
   output logic                      out_err
);

   localparam int DATA_W = GROUPS * GRP_W;
   localparam int LO_W   = (SHIFT_W + 1) / 2;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [SHIFT_W-1:0] shift;
      logic [GRP_W-1:0]   fill;
`ifdef SHIFT_RIGHT_PIPE_ROTATE_EN
      logic               mode;
`endif
      logic               err;
   } s1_t;

   // Shift right by a constant c groups; vacated groups take f (or wrap when rotating).
`ifdef SHIFT_RIGHT_PIPE_ROTATE_EN
   function automatic logic [DATA_W-1:0] grp_shr(
      input logic [DATA_W-1:0] d,
      input int                c,
      input logic [GRP_W-1:0]  f,
      input logic              rot
   );
      logic [DATA_W-1:0] r;
      r = '0;
      for (int g = 0; g < GROUPS; g++) begin
         if (g + c < GROUPS)
            r[g*GRP_W +: GRP_W] = d[(g+c)*GRP_W +: GRP_W];
         else if (rot)
            r[g*GRP_W +: GRP_W] = d[((g+c)%GROUPS)*GRP_W +: GRP_W];
         else
            r[g*GRP_W +: GRP_W] = f;
      end
      return r;
   endfunction
`else
   function automatic logic [DATA_W-1:0] grp_shr(
      input logic [DATA_W-1:0] d,
      input int                c,
      input logic [GRP_W-1:0]  f
   );
      logic [DATA_W-1:0] r;
      r = '0;
      for (int g = 0; g < GROUPS; g++) begin
         if (g + c < GROUPS)
            r[g*GRP_W +: GRP_W] = d[(g+c)*GRP_W +: GRP_W];
         else
            r[g*GRP_W +: GRP_W] = f;
      end
      return r;
   endfunction

   logic unused_mode;
   assign unused_mode = mode;
`endif

   s1_t               s1_q, s1_d;
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              out_err_q, out_err_d;

   logic              adv2, adv1;
   logic [DATA_W-1:0] sh1, sh2;

   assign adv2     = !out_valid_q || out_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign in_ready = adv1;

   // Stage 1 applies the low shift bits
   always_comb begin
      sh1 = in;
      for (int b = 0; b < SHIFT_W; b++) begin
         if (b < LO_W && shift[b]) begin
`ifdef SHIFT_RIGHT_PIPE_ROTATE_EN
            sh1 = grp_shr(sh1, 1 << b, fill, mode);
`else
            sh1 = grp_shr(sh1, 1 << b, fill);
`endif
         end
      end
   end

   always_comb begin
      s1_d       = s1_q;
      s1_valid_d = s1_valid_q;
      if (adv1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_d.data  = sh1;
            s1_d.shift = shift;
            s1_d.fill  = fill;
`ifdef SHIFT_RIGHT_PIPE_ROTATE_EN
            s1_d.mode  = mode;
`endif
            s1_d.err   = (shift > SHIFT_W'(MAX_SHIFT));
         end
      end
   end

   // Stage 2 applies the remaining high shift bits
   always_comb begin
      sh2 = s1_q.data;
      for (int b = 0; b < SHIFT_W; b++) begin
         if (b >= LO_W && s1_q.shift[b]) begin
`ifdef SHIFT_RIGHT_PIPE_ROTATE_EN
            sh2 = grp_shr(sh2, 1 << b, s1_q.fill, s1_q.mode);
`else
            sh2 = grp_shr(sh2, 1 << b, s1_q.fill);
`endif
         end
      end
   end

   always_comb begin
      out_d       = out_q;
      out_err_d   = out_err_q;
      out_valid_d = out_valid_q;
      if (adv2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_d     = s1_q.err ? {GROUPS{s1_q.fill}} : sh2;
            out_err_d = s1_q.err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         out_q       <= '0;
         out_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         out_q       <= out_d;
         out_err_q   <= out_err_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_err   = out_err_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_right_pipe.sv
// Directed self-checking bench for shift_right_pipe (default parameters).
// Rotate expectations follow SHIFT_RIGHT_PIPE_ROTATE_EN when it is defined.
module tb_shift_right_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [49:0] din;
   logic [2:0]  shift;
   logic [4:0]  fill;
   logic        mode;
   logic        out_valid;
   logic        out_ready;
   logic [49:0] dout;
   logic        out_err;

   int checks = 0;
   int errors = 0;

   logic [49:0] va, vb, vc, vd, ve, vg, exp_g;

   shift_right_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (din),
      .shift     (shift),
      .fill      (fill),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (dout),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input string tag, input logic [49:0] d,
                       input logic [2:0] s, input logic [4:0] f,
                       input logic m, input logic [49:0] eo,
                       input logic ee);
      @(negedge clk);
      din = d; shift = s; fill = f; mode = m;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 check({tag, "_rdy"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_early"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      check({tag, "_vld"}, 64'(out_valid), 64'd1);
      check({tag, "_out"}, 64'(dout), 64'(eo));
      check({tag, "_err"}, 64'(out_err), 64'(ee));
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; din = '0; shift = '0;
      fill = '0; mode = 1'b0; out_ready = 1'b1;
      #1;
      check("rst_vld", 64'(out_valid), 64'd0);
      check("rst_out", 64'(dout), 64'd0);
      check("rst_err", 64'(out_err), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rdy", 64'(in_ready), 64'd1);

      send("shr2", 50'h3_FFFF_FFFF_FFFF, 3'd2, 5'h00, 1'b0,
           50'h0_00FF_FFFF_FFFF, 1'b0);
`ifdef SHIFT_RIGHT_PIPE_ROTATE_EN
      send("rot1", 50'h0_0000_0000_001F, 3'd1, 5'h00, 1'b1,
           50'h3_E000_0000_0000, 1'b0);
`else
      send("rot1", 50'h0_0000_0000_001F, 3'd1, 5'h00, 1'b1,
           50'h0, 1'b0);
`endif
      send("bad5", 50'h1_2345_6789_ABCD, 3'd5, 5'h15, 1'b0,
           50'h2_B5AD_6B5A_D6B5, 1'b1);
      send("bad7r", 50'h3_0000_FFFF_0000, 3'd7, 5'h0A, 1'b1,
           {10{5'h0A}}, 1'b1);
      send("pass0", 50'h1_2345_6789_ABCD, 3'd0, 5'h1F, 1'b1,
           50'h1_2345_6789_ABCD, 1'b0);
      send("max4", 50'h0, 3'd4, 5'h1F, 1'b0,
           50'h3_FFFF_C000_0000, 1'b0);
      vg    = 50'h2_AAAA_5555_1234;
      exp_g = (vg >> 15) | ({35'd0, 15'h0C63} << 35);
      send("shr3", vg, 3'd3, 5'h03, 1'b0, exp_g, 1'b0);

      // Backpressure: A reaches output, stall 3 cycles, then A,B,C in order
      va = 50'h0_0000_0000_0AAA;
      vb = 50'h0_0000_0000_0BBB;
      vc = 50'h0_0000_0000_0CCC;
      @(negedge clk);
      shift = 3'd0; fill = 5'h00; mode = 1'b0; out_ready = 1'b1;
      din = va; in_valid = 1'b1;
      @(negedge clk);
      din = vb;
      @(negedge clk);
      check("bp_a_first", 64'(dout), 64'(va));
      out_ready = 1'b0;
      din = vc;
      #1 check("bp_rdy_drop", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_hold_out", 64'(dout), 64'(va));
         check("bp_hold_vld", 64'(out_valid), 64'd1);
         check("bp_hold_rdy", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      #1 check("bp_rdy_back", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_b", 64'(dout), 64'(vb));
      check("bp_b_vld", 64'(out_valid), 64'd1);
      @(negedge clk);
      check("bp_c", 64'(dout), 64'(vc));
      check("bp_c_vld", 64'(out_valid), 64'd1);
      @(negedge clk);
      check("bp_drain", 64'(out_valid), 64'd0);

      // Reset with two beats in flight
      vd = 50'h1_1111_1111_1111;
      ve = 50'h2_2222_2222_2222;
      @(negedge clk);
      din = vd; shift = 3'd5; fill = 5'h15; in_valid = 1'b1;
      @(negedge clk);
      din = ve; shift = 3'd0;
      @(negedge clk);
      in_valid = 1'b0;
      check("rf_pre_vld", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rf_vld", 64'(out_valid), 64'd0);
      check("rf_out", 64'(dout), 64'd0);
      check("rf_err", 64'(out_err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rf_rdy", 64'(in_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check("rf_no_beat", 64'(out_valid), 64'd0);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
